// File: rtl/pipeline_hazard_controller.sv
// Decode-side hazard unit: per-register in-flight write scoreboard, RAW/saturation stalls, redirect flush.
// Optional perf counters enabled by defining HAZARD_STATS_EN; otherwise stall_cycles/flush_cycles read 0.
module pipeline_hazard_controller #(
  parameter int MAX_INFLIGHT = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rs1_ID,
  input  logic [3:0]  rs2_ID,
  input  logic        rs1_used_ID,
  input  logic        rs2_used_ID,
  input  logic [3:0]  rd_ID,
  input  logic        regfile_we_ID,
  input  logic        invalid_ID,
  input  logic        redirect_EX,
  input  logic        stall_ext,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rd,
  output logic        stall,
  output logic        stall_ID,
  output logic        bubble_EX,
  output logic        flush_ID,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
);

  localparam int CW = $clog2(MAX_INFLIGHT + 1);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {RUN, FLUSH} state_t;

  state_t         state, state_nxt;
  logic [FW-1:0]  fcnt, fcnt_nxt;
  logic [CW-1:0]  cnt [16];

  logic valid_ID, raw, sat, hazard, flushing, issue;

  always_comb begin
    valid_ID = !invalid_ID;
    raw = valid_ID &
          ((rs1_used_ID && rs1_ID != 4'd0 && cnt[rs1_ID] != '0) ||
           (rs2_used_ID && rs2_ID != 4'd0 && cnt[rs2_ID] != '0));
    sat = valid_ID & regfile_we_ID & (rd_ID != 4'd0) &
          (cnt[rd_ID] == CW'(MAX_INFLIGHT));
    hazard   = raw | sat;
    flushing = redirect_EX | (state == FLUSH);
    issue    = valid_ID & !stall_ext & !flushing & !hazard;
  end

  always_comb begin
    stall     = 1'b0;
    stall_ID  = 1'b0;
    bubble_EX = 1'b0;
    flush_ID  = 1'b0;
    if (rst) begin
      bubble_EX = 1'b1;
      flush_ID  = 1'b1;
    end else if (stall_ext) begin
      stall = 1'b1;
    end else begin
      flush_ID  = flushing;
      bubble_EX = flushing | hazard;
      stall_ID  = !flushing & hazard;
    end
  end

  // The redirect cycle itself is the first flush cycle, so FLUSH covers the remaining FLUSH_CYCLES-1.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    if (!stall_ext) begin
      case (state)
        RUN: begin
          if (redirect_EX && FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            fcnt_nxt  = FW'(FLUSH_CYCLES - 1);
          end
        end
        FLUSH: begin
          if (fcnt <= FW'(1)) begin
            state_nxt = RUN;
            fcnt_nxt  = '0;
          end else begin
            fcnt_nxt = fcnt - FW'(1);
          end
        end
        default: begin
          state_nxt = RUN;
          fcnt_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // x0 is never tracked; a writeback to an idle register is dropped rather than underflowing.
  always_ff @(posedge clk) begin
    cnt[0] <= '0;
    for (int i = 1; i < 16; i++) begin
      if (rst) begin
        cnt[i] <= '0;
      end else begin
        if (issue && regfile_we_ID && rd_ID == 4'(i)) begin
          if (!(wb_valid && wb_rd == 4'(i)))
            cnt[i] <= cnt[i] + CW'(1);
        end else if (wb_valid && wb_rd == 4'(i) && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CW'(1);
        end
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall || stall_ID) stall_cnt <= stall_cnt + 32'd1;
      if (flush_ID)          flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_cycles = flush_cnt;
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MAX_INFLIGHT=3, FLUSH_CYCLES=2).
module tb_pipeline_hazard_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  rs1_ID, rs2_ID, rd_ID, wb_rd;
  logic        rs1_used_ID, rs2_used_ID, regfile_we_ID, invalid_ID;
  logic        redirect_EX, stall_ext, wb_valid;
  logic        stall, stall_ID, bubble_EX, flush_ID;
  logic [31:0] stall_cycles, flush_cycles;

  int errors = 0;
  int checks = 0;

  pipeline_hazard_controller #(.MAX_INFLIGHT(3), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
    .rd_ID(rd_ID), .regfile_we_ID(regfile_we_ID), .invalid_ID(invalid_ID),
    .redirect_EX(redirect_EX), .stall_ext(stall_ext),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .stall_ID(stall_ID), .bubble_EX(bubble_EX), .flush_ID(flush_ID),
    .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_ID = 4'd0; rs2_ID = 4'd0; rd_ID = 4'd0; wb_rd = 4'd0;
    rs1_used_ID = 1'b0; rs2_used_ID = 1'b0; regfile_we_ID = 1'b0;
    invalid_ID = 1'b1; redirect_EX = 1'b0; stall_ext = 1'b0; wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    tick(); tick();
    stall_ext = 1'b1; redirect_EX = 1'b1; invalid_ID = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", stall); end
    checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL rst_stall_ID: got %b expected 0", stall_ID); end
    checks++; if (bubble_EX !== 1'b1) begin errors++; $display("FAIL rst_bubble: got %b expected 1", bubble_EX); end
    checks++; if (flush_ID !== 1'b1) begin errors++; $display("FAIL rst_flush: got %b expected 1", flush_ID); end
    checks++; if (stall_cycles !== 32'd0 || flush_cycles !== 32'd0) begin
      errors++; $display("FAIL rst_counters: got %0d/%0d expected 0/0", stall_cycles, flush_cycles); end
    idle();
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({stall, stall_ID, bubble_EX, flush_ID} !== 4'b0000) begin
      errors++; $display("FAIL post_rst_idle: got %b expected 0000", {stall, stall_ID, bubble_EX, flush_ID}); end
  endtask

  task automatic test_raw();
    idle();
    invalid_ID = 1'b0; rd_ID = 4'd5; regfile_we_ID = 1'b1;
    #1;
    checks++; if (stall_ID !== 1'b0 || bubble_EX !== 1'b0) begin
      errors++; $display("FAIL raw_issue: got stall_ID=%b bubble=%b expected 0 0", stall_ID, bubble_EX); end
    tick();
    rd_ID = 4'd6; rs1_ID = 4'd5; rs1_used_ID = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (stall_ID !== 1'b1 || bubble_EX !== 1'b1 || stall !== 1'b0) begin
        errors++; $display("FAIL raw_hold%0d: got stall_ID=%b bubble=%b stall=%b expected 1 1 0", k, stall_ID, bubble_EX, stall); end
      tick();
    end
    wb_valid = 1'b1; wb_rd = 4'd5;
    #1;
    checks++; if (stall_ID !== 1'b1) begin errors++; $display("FAIL raw_wb_cycle: got %b expected 1", stall_ID); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++; if (stall_ID !== 1'b0 || bubble_EX !== 1'b0) begin
      errors++; $display("FAIL raw_release: got stall_ID=%b bubble=%b expected 0 0", stall_ID, bubble_EX); end
    tick();
    idle(); wb_valid = 1'b1; wb_rd = 4'd6;
    tick();
    idle(); invalid_ID = 1'b0; rs1_ID = 4'd5; rs1_used_ID = 1'b1; rs2_ID = 4'd6; rs2_used_ID = 1'b1;
    #1;
    checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL raw_cnt_clear: got %b expected 0", stall_ID); end
    idle();
  endtask

  task automatic test_x0();
    idle();
    invalid_ID = 1'b0; rs1_used_ID = 1'b1; rs2_used_ID = 1'b1; regfile_we_ID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (stall_ID !== 1'b0 || bubble_EX !== 1'b0) begin
        errors++; $display("FAIL x0_nostall%0d: got stall_ID=%b bubble=%b expected 0 0", k, stall_ID, bubble_EX); end
      tick();
    end
    regfile_we_ID = 1'b0; rs2_used_ID = 1'b0;
    for (int r = 1; r < 16; r++) begin
      rs1_ID = 4'(r);
      #1;
      checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL x0_cnt_zero x%0d: got %b expected 0", r, stall_ID); end
    end
    idle();
  endtask

  task automatic test_flush();
    logic [31:0] fc0;
    idle();
    fc0 = flush_cycles;
    invalid_ID = 1'b0; rd_ID = 4'd9; regfile_we_ID = 1'b1; redirect_EX = 1'b1;
    #1;
    checks++; if (flush_ID !== 1'b1 || bubble_EX !== 1'b1 || stall_ID !== 1'b0) begin
      errors++; $display("FAIL flush_c0: got flush=%b bubble=%b stall_ID=%b expected 1 1 0", flush_ID, bubble_EX, stall_ID); end
    tick();
    redirect_EX = 1'b0;
    #1;
    checks++; if (flush_ID !== 1'b1 || bubble_EX !== 1'b1) begin
      errors++; $display("FAIL flush_c1: got flush=%b bubble=%b expected 1 1", flush_ID, bubble_EX); end
    tick();
    regfile_we_ID = 1'b0; rs1_ID = 4'd9; rs1_used_ID = 1'b1;
    #1;
    checks++; if (flush_ID !== 1'b0 || bubble_EX !== 1'b0 || stall_ID !== 1'b0) begin
      errors++; $display("FAIL flush_done_nocount: got flush=%b bubble=%b stall_ID=%b expected 0 0 0", flush_ID, bubble_EX, stall_ID); end
`ifdef HAZARD_STATS_EN
    checks++; if (flush_cycles !== fc0 + 32'd2) begin
      errors++; $display("FAIL flush_counter: got %0d expected %0d", flush_cycles, fc0 + 32'd2); end
`else
    checks++; if (flush_cycles !== 32'd0) begin errors++; $display("FAIL flush_counter_tied: got %0d expected 0", flush_cycles); end
`endif
    idle();
    tick();
  endtask

  task automatic test_saturation();
    idle();
    invalid_ID = 1'b0; rd_ID = 4'd7; regfile_we_ID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL sat_issue%0d: got %b expected 0", k, stall_ID); end
      tick();
    end
    #1;
    checks++; if (stall_ID !== 1'b1 || bubble_EX !== 1'b1) begin
      errors++; $display("FAIL sat_stall: got stall_ID=%b bubble=%b expected 1 1", stall_ID, bubble_EX); end
    tick();
    wb_valid = 1'b1; wb_rd = 4'd7;
    #1;
    checks++; if (stall_ID !== 1'b1) begin errors++; $display("FAIL sat_wb_cycle: got %b expected 1", stall_ID); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL sat_release: got %b expected 0", stall_ID); end
    tick();
    #1;
    checks++; if (stall_ID !== 1'b1) begin errors++; $display("FAIL sat_again: got %b expected 1", stall_ID); end
    wb_valid = 1'b1;
    tick();
    // count is now 2: a same-cycle issue and writeback must leave it at 2
    #1;
    checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL sat_issue_wb: got %b expected 0", stall_ID); end
    tick();
    wb_valid = 1'b0;
    #1;
    checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL sat_net_unchanged: got %b expected 0", stall_ID); end
    tick();
    #1;
    checks++; if (stall_ID !== 1'b1) begin errors++; $display("FAIL sat_full_again: got %b expected 1", stall_ID); end
    idle(); wb_valid = 1'b1; wb_rd = 4'd7;
    tick(); tick();
    wb_valid = 1'b0; invalid_ID = 1'b0; rs1_ID = 4'd7; rs1_used_ID = 1'b1;
    #1;
    checks++; if (stall_ID !== 1'b1) begin errors++; $display("FAIL sat_partial_drain: got %b expected 1", stall_ID); end
    invalid_ID = 1'b1; wb_valid = 1'b1;
    tick();
    wb_valid = 1'b0; invalid_ID = 1'b0;
    #1;
    checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL sat_drained: got %b expected 0", stall_ID); end
    idle();
  endtask

  task automatic test_stall_ext();
    logic [31:0] sc0;
    idle();
    invalid_ID = 1'b0; rd_ID = 4'd5; regfile_we_ID = 1'b1;
    tick();
    rd_ID = 4'd0; regfile_we_ID = 1'b0; rs1_ID = 4'd5; rs1_used_ID = 1'b1;
    stall_ext = 1'b1; wb_valid = 1'b1; wb_rd = 4'd5;
    #1;
    sc0 = stall_cycles;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if ({stall, stall_ID, bubble_EX, flush_ID} !== 4'b1000) begin
        errors++; $display("FAIL stext_cycle%0d: got %b expected 1000", k, {stall, stall_ID, bubble_EX, flush_ID}); end
      tick();
      wb_valid = 1'b0;
    end
    stall_ext = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || stall_ID !== 1'b0) begin
      errors++; $display("FAIL stext_cnt_dec: got stall=%b stall_ID=%b expected 0 0", stall, stall_ID); end
`ifdef HAZARD_STATS_EN
    checks++; if (stall_cycles !== sc0 + 32'd4) begin
      errors++; $display("FAIL stext_counter: got %0d expected %0d", stall_cycles, sc0 + 32'd4); end
`else
    checks++; if (stall_cycles !== 32'd0 || sc0 !== 32'd0) begin
      errors++; $display("FAIL stext_counter_tied: got %0d expected 0", stall_cycles); end
`endif
    idle();
    tick();
  endtask

  task automatic test_rst_mid_flush();
    idle();
    invalid_ID = 1'b0; rd_ID = 4'd3; regfile_we_ID = 1'b1;
    tick(); tick();
    regfile_we_ID = 1'b0; rs1_ID = 4'd3; rs1_used_ID = 1'b1;
    #1;
    checks++; if (stall_ID !== 1'b1) begin errors++; $display("FAIL rstf_cnt_pending: got %b expected 1", stall_ID); end
    invalid_ID = 1'b1; redirect_EX = 1'b1;
    tick();
    redirect_EX = 1'b0;
    #1;
    checks++; if (flush_ID !== 1'b1) begin errors++; $display("FAIL rstf_in_flush: got %b expected 1", flush_ID); end
    rst = 1'b1;
    #1;
    checks++; if ({stall, stall_ID, bubble_EX, flush_ID} !== 4'b0011) begin
      errors++; $display("FAIL rstf_during_rst: got %b expected 0011", {stall, stall_ID, bubble_EX, flush_ID}); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (flush_ID !== 1'b0 || bubble_EX !== 1'b0) begin
      errors++; $display("FAIL rstf_run: got flush=%b bubble=%b expected 0 0", flush_ID, bubble_EX); end
    invalid_ID = 1'b0;
    #1;
    checks++; if (stall_ID !== 1'b0) begin errors++; $display("FAIL rstf_cnt_clear: got %b expected 0", stall_ID); end
    idle();
    tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_raw();
    test_x0();
    test_flush();
    test_saturation();
    test_stall_ext();
    test_rst_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
